// File: rtl/pipe_ctrl.sv
// Five-stage pipeline controller: stall arbitration, exception/ERET flush and redirect,
// post-flush refill window and stall watchdog. Optional perf counters under CTRL_PERF_CNT_EN.
module pipe_ctrl #(
    parameter logic [31:0] EXC_VEC    = 32'h0000_0020,
    parameter logic [31:0] ERET_TYPE  = 32'h0000_000e,
    parameter int unsigned REFILL_CYC = 2,
    parameter int unsigned MAX_STALL  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        stall_timeout_o
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_o,
    output logic [15:0] perf_flush_o
`endif
);

    localparam int unsigned STALL_CW  = 8;
    localparam int unsigned REFILL_CW = 4;

    localparam logic [5:0] STALL_EX = 6'b001111;
    localparam logic [5:0] STALL_ID = 6'b000111;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        REFILL = 1'b1
    } state_t;

    state_t                 state, state_nxt;
    logic [REFILL_CW-1:0]   refill_cnt, refill_cnt_nxt;
    logic [STALL_CW-1:0]    stall_cnt;
    logic                   stalling;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            refill_cnt <= '0;
        end else begin
            state      <= state_nxt;
            refill_cnt <= refill_cnt_nxt;
        end
    end

    // Next state and same-cycle stall/flush/redirect outputs
    always_comb begin
        state_nxt      = state;
        refill_cnt_nxt = refill_cnt;
        stall_o        = '0;
        flush_o        = 1'b0;
        new_pc_o       = '0;

        if (stallreq_ex)
            stall_o = STALL_EX;
        else if (stallreq_id)
            stall_o = STALL_ID;

        case (state)
            RUN: begin
                if (excepttype_i != 32'd0) begin
                    // Flush wins over any stall request
                    flush_o        = 1'b1;
                    stall_o        = '0;
                    new_pc_o       = (excepttype_i == ERET_TYPE) ? cp0_epc_i : EXC_VEC;
                    state_nxt      = REFILL;
                    refill_cnt_nxt = REFILL_CW'(REFILL_CYC - 1);
                end
            end
            REFILL: begin
                if (refill_cnt == '0)
                    state_nxt = RUN;
                else
                    refill_cnt_nxt = refill_cnt - REFILL_CW'(1);
            end
            default: state_nxt = RUN;
        endcase

        if (rst) begin
            stall_o  = '0;
            flush_o  = 1'b0;
            new_pc_o = '0;
        end
    end

    assign stalling = (stall_o != 6'd0);

    // Consecutive-stall counter and sticky watchdog flag
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt       <= '0;
            stall_timeout_o <= 1'b0;
        end else begin
            if (flush_o || !stalling)
                stall_cnt <= '0;
            else if (stall_cnt != {STALL_CW{1'b1}})
                stall_cnt <= stall_cnt + STALL_CW'(1);

            if (stalling && (stall_cnt >= STALL_CW'(MAX_STALL - 1)))
                stall_timeout_o <= 1'b1;
        end
    end

`ifdef CTRL_PERF_CNT_EN
    // Free-running event counters, wrap naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_o <= '0;
            perf_flush_o <= '0;
        end else begin
            if (stalling)
                perf_stall_o <= perf_stall_o + 32'd1;
            if (flush_o)
                perf_flush_o <= perf_flush_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: driver pushes hand-computed expectations per cycle,
// negedge monitor pops and compares.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        stall_timeout_o;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] perf_stall_o;
    logic [15:0] perf_flush_o;
`endif

    pipe_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .stallreq_id     (stallreq_id),
        .stallreq_ex     (stallreq_ex),
        .excepttype_i    (excepttype_i),
        .cp0_epc_i       (cp0_epc_i),
        .stall_o         (stall_o),
        .flush_o         (flush_o),
        .new_pc_o        (new_pc_o),
        .stall_timeout_o (stall_timeout_o)
`ifdef CTRL_PERF_CNT_EN
        ,
        .perf_stall_o    (perf_stall_o),
        .perf_flush_o    (perf_flush_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic        timeout;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    // Monitor: outputs are valid every cycle, compare one expectation per cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_checks++;
            if (stall_o === e.stall && flush_o === e.flush &&
                new_pc_o === e.pc && stall_timeout_o === e.timeout) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got stall=%b flush=%b pc=%h to=%b, expected stall=%b flush=%b pc=%h to=%b",
                         nm, stall_o, flush_o, new_pc_o, stall_timeout_o,
                         e.stall, e.flush, e.pc, e.timeout);
            end
        end
    end

    task automatic step(input logic r, input logic sid, input logic sex,
                        input logic [31:0] exc, input logic [31:0] epc,
                        input logic [5:0] es, input logic ef, input logic [31:0] epcx,
                        input logic eto, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = r;
        stallreq_id  = sid;
        stallreq_ex  = sex;
        excepttype_i = exc;
        cp0_epc_i    = epc;
        e.stall   = es;
        e.flush   = ef;
        e.pc      = epcx;
        e.timeout = eto;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    localparam logic [5:0] SX = 6'b001111;
    localparam logic [5:0] SI = 6'b000111;

    initial begin
        int wait_cyc;
        rst = 1'b1; stallreq_id = 1'b0; stallreq_ex = 1'b0;
        excepttype_i = '0; cp0_epc_i = '0;

        // Second reset cycle: registered state already cleared
        step(1, 0, 0, 0, 0, 6'd0, 0, 32'd0, 0, "reset");
        step(0, 0, 0, 0, 0, 6'd0, 0, 32'd0, 0, "idle");
        step(0, 1, 0, 0, 0, SI,   0, 32'd0, 0, "stall_id");
        step(0, 1, 1, 0, 0, SX,   0, 32'd0, 0, "stall_id_ex");
        step(0, 0, 0, 0, 0, 6'd0, 0, 32'd0, 0, "stall_release");

        // Exception with concurrent stall, then refill window of 2 cycles
        step(0, 0, 1, 32'h8, 0, 6'd0, 1, 32'h20, 0, "exc_over_stall");
        step(0, 0, 0, 32'h8, 0, 6'd0, 0, 32'd0,  0, "refill_ignore1");
        step(0, 1, 0, 32'h8, 0, SI,   0, 32'd0,  0, "refill_ignore2_stall");
        step(0, 0, 0, 32'h8, 0, 6'd0, 1, 32'h20, 0, "exc_after_refill");
        step(0, 0, 0, 0, 0, 6'd0, 0, 32'd0, 0, "refill_a");
        step(0, 0, 0, 0, 0, 6'd0, 0, 32'd0, 0, "refill_b");

        // ERET redirects to EPC
        step(0, 0, 0, 32'he, 32'h1234, 6'd0, 1, 32'h1234, 0, "eret");
        step(0, 0, 0, 0, 0, 6'd0, 0, 32'd0, 0, "refill_c");
        step(0, 0, 0, 0, 0, 6'd0, 0, 32'd0, 0, "refill_d");

        // 15 stalled cycles stays below the watchdog threshold
        for (int i = 0; i < 15; i++)
            step(0, 0, 1, 0, 0, SX, 0, 32'd0, 0, "stall15");
        step(0, 0, 0, 0, 0, 6'd0, 0, 32'd0, 0, "no_timeout_15");

        // 16 stalled cycles trips it after the last one
        for (int i = 0; i < 16; i++)
            step(0, 0, 1, 0, 0, SX, 0, 32'd0, 0, "stall16");
        step(0, 0, 0, 0, 0, 6'd0, 0, 32'd0, 1, "timeout_set");
        step(0, 1, 0, 0, 0, SI,   0, 32'd0, 1, "timeout_sticky");
        step(1, 1, 1, 32'h8, 0, 6'd0, 0, 32'd0, 1, "rst_forces_zero");
        step(0, 0, 0, 0, 0, 6'd0, 0, 32'd0, 0, "timeout_cleared");

        // Reset in the middle of a refill window returns to RUN
        step(0, 0, 0, 32'h8, 0, 6'd0, 1, 32'h20, 0, "exc_pre_rst");
        step(1, 0, 0, 32'h8, 0, 6'd0, 0, 32'd0,  0, "rst_mid_refill");
        step(0, 0, 0, 32'h8, 0, 6'd0, 1, 32'h20, 0, "exc_post_rst");
        step(0, 0, 0, 0, 0, 6'd0, 0, 32'd0, 0, "refill_e");
        step(0, 0, 0, 0, 0, 6'd0, 0, 32'd0, 0, "refill_f");

`ifdef CTRL_PERF_CNT_EN
        step(1, 0, 0, 0, 0, 6'd0, 0, 32'd0, 0, "perf_rst");
        for (int i = 0; i < 5; i++)
            step(0, 1, 0, 0, 0, SI, 0, 32'd0, 0, "perf_stall");
        step(0, 0, 0, 32'h8, 0, 6'd0, 1, 32'h20, 0, "perf_flush1");
        step(0, 0, 0, 0, 0, 6'd0, 0, 32'd0, 0, "perf_refill1");
        step(0, 0, 0, 0, 0, 6'd0, 0, 32'd0, 0, "perf_refill2");
        step(0, 0, 0, 32'h8, 0, 6'd0, 1, 32'h20, 0, "perf_flush2");
        step(0, 0, 0, 0, 0, 6'd0, 0, 32'd0, 0, "perf_idle");
        n_checks++;
        if (perf_stall_o === 32'd5 && perf_flush_o === 16'd2)
            n_pass++;
        else
            $display("FAIL perf_counts: got stall=%0d flush=%0d, expected stall=5 flush=2",
                     perf_stall_o, perf_flush_o);
`endif

        // Drain the scoreboard with a bounded wait
        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline controller for the five-stage core. Arbitrates stall requests from ID (load-use) and EX (multi-cycle ops) and exception/ERET flush requests from MEM. Drives the per-stage stall vector consumed by the PC register and every inter-stage register (if_id, id_ex, ex_mem, mem_wb), plus the flush strobe and redirect PC. Holds a post-flush refill window and a stall watchdog.

Parameters:
EXC_VEC, 32'h0000_0020, redirect target for every exception except ERET
ERET_TYPE, 32'h0000_000e, excepttype code meaning ERET (redirect to EPC)
REFILL_CYC, 2, cycles after a flush during which new exceptions are ignored (1..15)
MAX_STALL, 16, consecutive stall cycles that trip the watchdog (2..255)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  reset, synchronous, active-high
stallreq_id  in  1  ID stage requests stall (load-use hazard)
stallreq_ex  in  1  EX stage requests stall (multi-cycle op in progress)
excepttype_i  in  32  MEM-stage exception type; nonzero = exception pending
cp0_epc_i  in  32  current EPC from CP0
stall_o  out  6  stall vector: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
flush_o  out  1  flush all inter-stage registers this cycle
new_pc_o  out  32  redirect PC, valid when flush_o=1
stall_timeout_o  out  1  sticky watchdog flag

Behaviour:
- Registered state: fsm (RUN, REFILL), refill_cnt[3:0], stall_cnt[7:0], timeout flag. stall_o, flush_o, new_pc_o are combinational from state + inputs (same-cycle effect).
- Reset (rst=1 at posedge): fsm=RUN, refill_cnt=0, stall_cnt=0, stall_timeout_o=0. While rst=1, outputs forced to stall_o=0, flush_o=0, new_pc_o=0.
- RUN priority, highest first:
  - excepttype_i!=0: flush_o=1, stall_o=0, new_pc_o=cp0_epc_i if excepttype_i==ERET_TYPE else EXC_VEC. Next: REFILL, refill_cnt=REFILL_CYC-1.
  - stallreq_ex: stall_o=6'b001111.
  - stallreq_id: stall_o=6'b000111.
  - else: stall_o=0.
  - flush_o=0 and new_pc_o=0 whenever no exception is taken.
- REFILL: excepttype_i ignored (flush_o=0). Stall requests are arbitrated as in RUN. Each cycle: if refill_cnt==0 go to RUN, else decrement. A REFILL window therefore lasts exactly REFILL_CYC cycles; an exception is accepted on the first cycle after the window ends.
- Flush overrides stall: simultaneous exception and stall request gives flush_o=1, stall_o=0.
- Watchdog:
  - stall_cnt increments (saturating at 255) each cycle stall_o!=0 and clears to 0 when stall_o==0.
  - When stall_cnt reaches MAX_STALL-1 while still stalling, stall_timeout_o is set on the next edge and stays at 1 until rst.
  - A flush clears stall_cnt.
- Reset mid-REFILL or mid-stall returns to RUN next edge, and all counters clear.

Optional Feature:
Macro CTRL_PERF_CNT_EN.
- Defined: adds output ports perf_stall_o[31:0] and perf_flush_o[15:0].
  - perf_stall_o increments every cycle stall_o!=0.
  - perf_flush_o increments every cycle flush_o=1.
  - Both counters wrap modulo 2^N and clear on rst.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then idle with all requests 0 -> stall_o=0, flush_o=0, new_pc_o=0, stall_timeout_o=0.
- stallreq_id=1 for 1 cycle -> stall_o=6'b000111 that cycle; stallreq_id and stallreq_ex both 1 -> 6'b001111.
- excepttype_i=32'h8 with stallreq_ex=1 -> flush_o=1, stall_o=0, new_pc_o=32'h20. A second excepttype_i=32'h8 on the next 2 cycles -> flush_o=0. On the 3rd cycle -> flush_o=1.
- excepttype_i=32'he, cp0_epc_i=32'h1234 -> flush_o=1, new_pc_o=32'h0000_1234.
- stallreq_ex held 16 cycles (MAX_STALL=16) -> stall_timeout_o rises after the 16th stalled cycle and stays 1 after stallreq_ex drops. rst -> 0.
- CTRL_PERF_CNT_EN: 5 stall cycles + 2 flushes -> perf_stall_o=5, perf_flush_o=2. Preload-free wrap: 65536 flushes -> perf_flush_o=0.
